// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode/ext encodings, FSM state and ALU operation types
//               for the multicycle cpu_core. Honours CPU_MULTIPLY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_BEQZ  = 4'hC;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hE;

    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_MOV  = 4'hD;
    localparam logic [3:0] EXT_MUL  = 4'hE;

    localparam logic [3:0] EXT_LOAD = 4'h0;
    localparam logic [3:0] EXT_STOR = 4'h4;
    localparam logic [3:0] EXT_JAL  = 4'h8;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND   = 3'd0,
        ALU_OR    = 3'd1,
        ALU_XOR   = 3'd2,
        ALU_ADD   = 3'd3,
        ALU_SUB   = 3'd4,
        ALU_PASSB = 3'd5,
        ALU_MUL   = 3'd6,
        ALU_NOP   = 3'd7
    } alu_op_t;

    // Register-form ext field to ALU operation; unknown ext values become NOPs.
    function automatic alu_op_t f_rtype_op(input logic [3:0] ext);
        alu_op_t op;
        case (ext)
            EXT_AND: op = ALU_AND;
            EXT_OR:  op = ALU_OR;
            EXT_XOR: op = ALU_XOR;
            EXT_ADD: op = ALU_ADD;
            EXT_SUB: op = ALU_SUB;
            EXT_MOV: op = ALU_PASSB;
`ifdef CPU_MULTIPLY_EN
            EXT_MUL: op = ALU_MUL;
`endif
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// ============================================================================
// Module      : cpu_alu
// Description : Combinational WIDTH-bit ALU; the multiplier exists only when
//               CPU_MULTIPLY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_t          i_op,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            ALU_AND:   o_y = i_a & i_b;
            ALU_OR:    o_y = i_a | i_b;
            ALU_XOR:   o_y = i_a ^ i_b;
            ALU_ADD:   o_y = i_a + i_b;
            ALU_SUB:   o_y = i_a - i_b;
            ALU_PASSB: o_y = i_b;
`ifdef CPU_MULTIPLY_EN
            ALU_MUL:   o_y = i_a * i_b;
`endif
            default:   o_y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_core.sv
// ============================================================================
// Module      : cpu_core
// Description : Parametrised multicycle core, one instruction in flight, with a
//               request/ready memory port. Optional multiply: CPU_MULTIPLY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_core
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REGISTERS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] memory_read_data,
    input  logic             memory_ready,
    output logic             memory_request,
    output logic             memory_write_enable,
    output logic [WIDTH-1:0] memory_address,
    output logic [WIDTH-1:0] memory_write_data,
    output logic             halted
);

    localparam int C_RIDX_W = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [15:0]      r_ir;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_regs [REGISTERS];

    logic [3:0]       w_op;
    logic [3:0]       w_rd;
    logic [3:0]       w_ext;
    logic [3:0]       w_rs;
    logic [WIDTH-1:0] w_imm;
    logic             w_is_load;
    logic             w_is_stor;
    logic             w_is_jal;
    alu_op_t          w_alu_op;
    logic [WIDTH-1:0] w_alu_b;
    logic [WIDTH-1:0] w_alu_y;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_wr_ok;

    assign w_op      = r_ir[15:12];
    assign w_rd      = r_ir[11:8];
    assign w_ext     = r_ir[7:4];
    assign w_rs      = r_ir[3:0];
    assign w_imm     = {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
    assign w_is_load = (w_op == OP_MEM) && (w_ext == EXT_LOAD);
    assign w_is_stor = (w_op == OP_MEM) && (w_ext == EXT_STOR);
    assign w_is_jal  = (w_op == OP_MEM) && (w_ext == EXT_JAL);

    // Registers at or beyond REGISTERS read as zero.
    function automatic logic [WIDTH-1:0] f_reg_read(input logic [3:0] idx);
        logic [WIDTH-1:0] v;
        v = '0;
        if (int'(idx) < REGISTERS) begin
            v = r_regs[idx[C_RIDX_W-1:0]];
        end
        return v;
    endfunction

    always_comb begin
        w_alu_op = ALU_NOP;
        w_alu_b  = r_b;
        case (w_op)
            OP_RTYPE: w_alu_op = f_rtype_op(w_ext);
            OP_ADDI: begin
                w_alu_op = ALU_ADD;
                w_alu_b  = w_imm;
            end
            OP_MOVI: begin
                w_alu_op = ALU_PASSB;
                w_alu_b  = w_imm;
            end
            default: w_alu_op = ALU_NOP;
        endcase
    end

    cpu_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a  (r_a),
        .i_b  (w_alu_b),
        .i_op (w_alu_op),
        .o_y  (w_alu_y)
    );

    // Single register write port shared by EXECUTE and WRITEBACK.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = w_alu_y;
        if (r_state == ST_EXECUTE) begin
            if (w_is_jal) begin
                w_wr_en   = 1'b1;
                w_wr_data = r_pc;
            end else if (w_alu_op != ALU_NOP) begin
                w_wr_en   = 1'b1;
            end
        end else if (r_state == ST_WRITEBACK) begin
            w_wr_en   = 1'b1;
            w_wr_data = r_mdr;
        end
    end

    assign w_wr_ok = w_wr_en && (int'(w_rd) < REGISTERS);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_START;
            r_pc    <= '0;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mdr   <= '0;
            for (int i = 0; i < REGISTERS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_regs[w_rd[C_RIDX_W-1:0]] <= w_wr_data;
            end
            case (r_state)
                ST_START: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (memory_ready) begin
                        r_ir    <= memory_read_data[15:0];
                        r_pc    <= r_pc + C_ONE;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_a <= f_reg_read(w_rd);
                    r_b <= f_reg_read(w_rs);
                    if (w_is_load || w_is_stor) begin
                        r_state <= ST_MEMORY;
                    end else if (w_op == OP_HALT) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    // r_b was latched in DECODE, so JAL with rd == rs jumps to the old rs.
                    if (w_is_jal) begin
                        r_pc <= r_b;
                    end else if ((w_op == OP_BEQZ) && (r_a == '0)) begin
                        r_pc <= r_pc + w_imm;
                    end
                    r_state <= ST_FETCH;
                end
                ST_MEMORY: begin
                    if (memory_ready) begin
                        if (w_is_load) begin
                            r_mdr   <= memory_read_data;
                            r_state <= ST_WRITEBACK;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_WRITEBACK: r_state <= ST_FETCH;
                ST_HALT:      r_state <= ST_HALT;
                default:      r_state <= ST_START;
            endcase
        end
    end

    // Outputs depend on registered state only, never on memory_ready.
    always_comb begin
        memory_request      = (r_state == ST_FETCH) || (r_state == ST_MEMORY);
        memory_write_enable = (r_state == ST_MEMORY) && w_is_stor;
        memory_address      = '0;
        memory_write_data   = '0;
        if (r_state == ST_FETCH) begin
            memory_address = r_pc;
        end else if (r_state == ST_MEMORY) begin
            memory_address = r_b;
            if (w_is_stor) begin
                memory_write_data = r_a;
            end
        end
        halted = (r_state == ST_HALT);
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_core.sv
// ============================================================================
// Module      : tb_cpu_core
// Description : Scoreboard bench for cpu_core (WIDTH=32) with a wait-state
//               memory model. Expected multiply result follows CPU_MULTIPLY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_core;

    localparam int W = 32;
    localparam logic [15:0] I_HALT = 16'hE000;
`ifdef CPU_MULTIPLY_EN
    localparam logic [W-1:0] MUL_EXP = 32'd63;
`else
    localparam logic [W-1:0] MUL_EXP = 32'd7;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] memory_read_data;
    logic         memory_ready;
    logic         memory_request;
    logic         memory_write_enable;
    logic [W-1:0] memory_address;
    logic [W-1:0] memory_write_data;
    logic         halted;

    cpu_core #(
        .WIDTH     (W),
        .REGISTERS (16)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .memory_read_data    (memory_read_data),
        .memory_ready        (memory_ready),
        .memory_request      (memory_request),
        .memory_write_enable (memory_write_enable),
        .memory_address      (memory_address),
        .memory_write_data   (memory_write_data),
        .halted              (halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } txn_t;

    txn_t         sb_q[$];
    logic [W-1:0] mem [256];
    int           n_checks = 0;
    int           n_errors = 0;
    int           wait_n   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_f(input int lo, input int hi);
        txn_t t;
        for (int a = lo; a <= hi; a++) begin
            t = {1'b0, W'(a), {W{1'b0}}};
            sb_q.push_back(t);
        end
    endtask

    task automatic exp_w(input int a, input logic [W-1:0] d);
        txn_t t;
        t = {1'b1, W'(a), d};
        sb_q.push_back(t);
    endtask

    task automatic put(input int a, input logic [15:0] ins);
        mem[a] = {16'h0000, ins};
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = {16'h0000, I_HALT};
        end
        sb_q.delete();
    endtask

    task automatic run_to_halt(input int budget, input string tag);
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (halted) break;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    // Memory responder: completes each request after wait_n wait cycles and scores it.
    initial begin : responder
        int           cnt;
        logic [W-1:0] first_addr;
        txn_t         t;
        cnt              = 0;
        first_addr       = '0;
        memory_ready     = 1'b0;
        memory_read_data = '0;
        forever begin
            @(negedge clock);
            if (memory_ready || reset || !memory_request) cnt = 0;
            memory_ready     = 1'b0;
            memory_read_data = 32'hDEAD_BEEF;
            if (!reset && memory_request) begin
                if (cnt == 0) first_addr = memory_address;
                if (cnt >= wait_n) begin
                    memory_ready = 1'b1;
                    check("addr_hold", memory_address, first_addr);
                    if (sb_q.size() == 0) t = '1;
                    else                  t = sb_q.pop_front();
                    check("sb_we", {31'd0, memory_write_enable}, {31'd0, t.we});
                    check("sb_addr", memory_address, t.addr);
                    if (t.we) check("sb_wdata", memory_write_data, t.data);
                    memory_read_data = mem[memory_address[7:0]];
                    if (memory_write_enable) mem[memory_address[7:0]] = memory_write_data;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin : main
        int first;
        int hc;
        int reqs;

        // Run 1: MOVI/ADDI/HALT timing with ready high.
        clear_mem();
        put(0, 16'hD105);
        put(1, 16'h51FE);
        put(2, I_HALT);
        wait_n = 0;
        exp_f(0, 2);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_req", {31'd0, memory_request}, 32'd0);
        check("rst_we", {31'd0, memory_write_enable}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_addr", memory_address, 32'd0);
        check("rst_wdata", memory_write_data, 32'd0);
        reset = 1'b0;
        first = -1;
        hc    = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (memory_request && first < 0) first = c;
            if (halted) begin
                hc = c;
                break;
            end
        end
        check("halt_seen", {31'd0, halted}, 32'd1);
        check("first_req_cycle", W'(first), 32'd1);
        check("halt_latency", W'(hc - first), 32'd8);
        reqs = 0;
        repeat (10) begin
            @(negedge clock);
            if (memory_request) reqs++;
        end
        check("halt_quiet", W'(reqs), 32'd0);
        check("halt_hold", {31'd0, halted}, 32'd1);
        check("sb_empty_1", W'(sb_q.size()), 32'd0);

        // Run 1b: observe R1 = 5 + 0xFE(sext) = 3 through a store.
        clear_mem();
        put(0, 16'hD105);
        put(1, 16'h51FE);
        put(2, 16'hD240);
        put(3, 16'h4142);
        wait_n = 1;
        exp_f(0, 3); exp_w(32'h40, 32'd3); exp_f(4, 4);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_to_halt(200, "halt_1b");
        check("sb_empty_1b", W'(sb_q.size()), 32'd0);

        // Run 2: memory, ALU, multiply, sign extension, branches, JAL with 3 wait states.
        clear_mem();
        put(0, 16'hD240);  put(1, 16'hD37A);  put(2, 16'h4342);  put(3, 16'h4402);
        put(4, 16'hD541);  put(5, 16'h4445);  put(6, 16'hD10C);  put(7, 16'hD60A);
        put(8, 16'h0156);  put(9, 16'h4145);  put(10, 16'h0196); put(11, 16'h0116);
        put(12, 16'h0126); put(13, 16'h0133); put(14, 16'h4145); put(15, 16'h01D3);
        put(16, 16'h0171); put(17, 16'h4145); put(18, 16'hD207); put(19, 16'hD309);
        put(20, 16'h02E3); put(21, 16'h4245); put(22, 16'hD780); put(23, 16'h4745);
        put(24, 16'hC002); put(27, 16'hC105); put(28, 16'hC803); put(29, 16'hD560);
        put(30, 16'h4685); put(32, 16'hD801); put(33, 16'hC0FB);
        put(32'h60, 16'h4645); put(32'h61, 16'hD970); put(32'h62, 16'h4989);
        put(32'h70, 16'h4945);
        wait_n = 3;
        exp_f(0, 2);   exp_w(32'h40, 32'h7A);
        exp_f(3, 3);   exp_f(32'h40, 32'h40);
        exp_f(4, 5);   exp_w(32'h41, 32'h7A);
        exp_f(6, 9);   exp_w(32'h41, 32'h16);
        exp_f(10, 14); exp_w(32'h41, 32'h70);
        exp_f(15, 17); exp_w(32'h41, 32'h7A);
        exp_f(18, 21); exp_w(32'h41, MUL_EXP);
        exp_f(22, 23); exp_w(32'h41, 32'hFFFF_FF80);
        exp_f(24, 24); exp_f(27, 28); exp_f(32, 33); exp_f(29, 30);
        exp_f(32'h60, 32'h60); exp_w(32'h60, 32'h1F);
        exp_f(32'h61, 32'h62); exp_f(32'h70, 32'h70); exp_w(32'h60, 32'h63);
        exp_f(32'h71, 32'h71);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_to_halt(3000, "halt_2");
        check("sb_empty_2", W'(sb_q.size()), 32'd0);

        // Run 3: reset in the second wait cycle of a LOAD aborts it.
        clear_mem();
        put(0, 16'hD240);
        put(1, 16'h4402);
        wait_n = 3;
        exp_f(0, 1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (memory_request && memory_address == 32'h40) break;
        end
        check("load_pending", memory_address, 32'h40);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_req", {31'd0, memory_request}, 32'd0);
        check("sb_empty_3a", W'(sb_q.size()), 32'd0);
        // A store of R2 to [R0] exposes any register left over from before reset.
        put(0, 16'h4240);
        put(1, I_HALT);
        exp_f(0, 0); exp_w(0, 32'd0); exp_f(1, 1);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (memory_request) break;
        end
        check("first_req_after_abort", memory_address, 32'd0);
        run_to_halt(200, "halt_3");
        check("sb_empty_3b", W'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_core.md
# cpu_core

Parametrised multicycle processor core: single-issue, one instruction in flight, with controller FSM and datapath merged into one block. Successor of the fixed 16-bit core: adds a WIDTH parameter, a request/ready memory handshake tolerating wait states, branch/jump-and-link, and a halt state. Sits between the board top level and the unified instruction/data memory port.

## Interface
- WIDTH, 16: data, register, PC and address width; legal range 16–32.
- REGISTERS, 16: register-file depth; legal range 2–16; indices ≥ REGISTERS read 0, writes ignored.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- memory_read_data  input  WIDTH  read data; valid in the cycle memory_ready is high.
- memory_ready  input  1  completes the current transaction.
- memory_request  output  1  transaction pending.
- memory_write_enable  output  1  pending transaction is a write.
- memory_address  output  WIDTH  transaction address.
- memory_write_data  output  WIDTH  store data.
- halted  output  1  core stopped on HALT.

## Operation
- Instruction fields: op = [15:12], rd = [11:8], ext = [7:4], rs = [3:0]; imm8 = [7:0], sign-extended to WIDTH. Instructions are the low 16 bits of memory_read_data.
- op 0x0 (register ALU, rd ← rd OP rs): ext 0x1 AND, 0x2 OR, 0x3 XOR, 0x5 ADD, 0x9 SUB, 0xD MOV (rd ← rs); any other ext is a NOP.
- op 0x5 ADDI rd ← rd + imm8; op 0xD MOVI rd ← imm8.
- op 0x4: ext 0x0 LOAD rd ← M[rs]; ext 0x4 STOR M[rs] ← rd; ext 0x8 JAL rd ← PC+1, PC ← rs; other ext is a NOP.
- op 0xC BEQZ: if rd == 0, PC ← (PC+1) + imm8.
- op 0xE HALT. All other opcodes are NOPs.
- Arithmetic is modulo 2^WIDTH; no flags. The PC wraps from 2^WIDTH−1 to 0.
- FSM states: START, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
  - START → FETCH.
  - FETCH: request at PC; on ready, latch the instruction, PC ← PC+1, go to DECODE.
  - DECODE: read operands; LOAD/STOR → MEMORY, HALT → HALT, everything else → EXECUTE.
  - EXECUTE: ALU result, branch or JAL written; → FETCH.
  - MEMORY: request at R[rs]; on ready, LOAD → WRITEBACK, STOR → FETCH.
  - WRITEBACK: rd ← captured load data; → FETCH.
  - HALT: absorbing until reset.

## Timing
- Reset values: PC 0, all registers 0, state START; memory_request, memory_write_enable, halted are 0; memory_address and memory_write_data are 0.
- Outputs are decoded combinationally from registered state only; there is no combinational path from memory_ready to any output.
- memory_request is 1 exactly in FETCH and MEMORY. Address and write data hold stable while the request is pending.
- A transaction completes on the edge where request && ready. Any number of wait cycles is allowed.
- memory_write_enable = 1 only in MEMORY for STOR.
- Cycles per instruction with ready tied high: ALU/immediate/branch/JAL/STOR 3; LOAD 4; HALT reaches HALT after 2.
- The first fetch request appears in the cycle after reset deasserts (the START cycle).
- Reset during any state, including a pending transaction, aborts it. The request is low from the next cycle, and the memory must tolerate the abandoned request.
- JAL with rd == rs: the jump uses the old rs value, and rd receives PC+1.
- halted = 1 in HALT; memory_request is 0 in HALT.

## Configuration
- CPU_MULTIPLY_EN defined: op 0x0, ext 0xE computes rd ← low WIDTH bits of rd × rs (unsigned), still 3 cycles.
- CPU_MULTIPLY_EN undefined: ext 0xE is a NOP and no multiplier is synthesised.

## Structure
- cpu_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_MOVI, OP_MEM, OP_BEQZ, OP_HALT);
  - ext constants for ALU, memory and JAL;
  - the state enum;
  - the alu_op typedef.
- One sub-module, cpu_alu: combinational, WIDTH-parametrised; takes two operands and an alu_op, returns the result. The multiplier sits inside it under CPU_MULTIPLY_EN.

## Test plan
- MOVI R1,5; ADDI R1,0xFE; HALT with ready high → fetch addresses 0,1,2; R1 = 3; halted rises 8 cycles after reset release; no further requests.
- MOVI R2,0x40; MOVI R3,0x7A; STOR R3→[R2]; LOAD R4←[R2], with ready delayed 3 cycles per transaction → request and address held stable through each wait; write seen at 0x40 with data 0x7A; R4 = 0x7A.
- BEQZ R0,0xFE at address 5 → next fetch at 4. BEQZ with rd = 1 → next fetch at 6.
- MOVI R5,0x20; JAL R6,R5 at address 1 → next fetch at 0x20; R6 = 2. Then with WIDTH=32, MOVI R7,0x80 → R7 = 0xFFFFFF80.
- Reset asserted during the second wait cycle of a LOAD → request 0 the next cycle; PC and registers 0; first request after release is at address 0.
- R2=7, R3=9, op 0x0 ext 0xE rd=2 rs=3 → R2 = 63 with CPU_MULTIPLY_EN; R2 stays 7 without it.
